risc16_mc_cpu: RTL and testbench
================================

Name: risc16_mc_cpu

Overview:
Multicycle RiSC-16 core; the next generation of the single-cycle CPU. Uses one clock and one shared memory bus with a req/ack handshake, so instruction and data memories may have any latency. An explicit state machine sequences each instruction: FETCH, EXEC, optional MEM. The block adds a parametrised reset vector, parametrised address width, a halt state and a retired-instruction counter.

Parameters:
RESET_PC, 16'h0000, PC value loaded on reset.
ADDR_WIDTH, 16, mem_addr width (1..16); only the low ADDR_WIDTH bits of the internal 16-bit address are driven.
CNT_WIDTH, 32, width of the instret counter.

Ports:
clk  in  1  sole clock; all state updates on the rising edge.
reset  in  1  asynchronous, active-low reset.
mem_req  out  1  bus request.
mem_we  out  1  1 = write (sw); 0 = read (fetch or lw).
mem_addr  out  ADDR_WIDTH  word address.
mem_wdata  out  16  store data.
mem_rdata  in  16  read data; valid in the cycle mem_ack is high.
mem_ack  in  1  transfer completes on a rising edge where mem_req && mem_ack.
halt  out  1  high while in HALT.
pc_out  out  16  current PC.
instret  out  CNT_WIDTH  count of retired instructions.

Behaviour:
- Reset (reset==0, async): state=FETCH, pc=RESET_PC, ir=0, r1..r7=0, instret=0. mem_req, mem_we and halt go low immediately. mem_addr=RESET_PC, mem_wdata=0.
- r0 always reads 0; writes to r0 are discarded.
- ISA, with imm7 sign-extended to 16 bits and all arithmetic mod 2^16:
  - add 000: rA=rB+rC
  - addi 001: rA=rB+imm7
  - nand 010: rA=~(rB&rC)
  - lui 011: rA={imm10,6'b0}
  - sw 100: mem[rB+imm7]=rA
  - lw 101: rA=mem[rB+imm7]
  - beq 110: if rA==rB then pc=pc+1+imm7
  - jalr 111: rA=pc+1; pc=rB. Read rB before writing rA, so jalr rX,rX jumps to the old rX.
- FETCH: mem_req=1, mem_we=0, mem_addr=pc. On ack, ir<=mem_rdata and go to EXEC.
- EXEC: decodes ir; mem_req=0.
  - ir==16'hC07F (beq r0,r0,-1): instret++, go to HALT, pc unchanged.
  - add/addi/nand/lui/beq/jalr: write back, update pc (default pc+1), instret++, go to FETCH.
  - lw/sw: latch ea=rB+imm7 and, for sw, sdata=rA; go to MEM.
- MEM: mem_req=1, mem_addr=ea, mem_we=(sw), mem_wdata=sdata.
  - On ack: lw writes mem_rdata to rA; pc<=pc+1; instret++; go to FETCH.
- HALT: mem_req=0, halt=1. Stays in HALT until reset.
- Handshake rules:
  - mem_addr, mem_we and mem_wdata are stable while mem_req is high until the ack edge.
  - mem_req drops the cycle after the ack unless the next state also requests. MEM→FETCH requests back-to-back; FETCH→EXEC does not.
  - mem_ack with mem_req low is ignored.
  - Zero-wait ack (ack high in the same cycle req rises) is legal.
- Latency with zero-wait memory: ALU/branch/jalr take 2 cycles (FETCH, EXEC); lw/sw take 3 cycles. Each wait cycle adds 1.
- pc and address wrap mod 2^16. mem_addr is truncated to ADDR_WIDTH bits.
- instret wraps at 2^CNT_WIDTH.
- Reset mid-transfer abandons the transfer. No write-back occurs for an abandoned lw. Memory must tolerate a request that disappears without an ack.

Decomposition:
- risc16_pkg:
  - opcode localparams OP_ADD..OP_JALR
  - state enum {FETCH, EXEC, MEM, HALT}
  - HALT_INSTR=16'hC07F
  - function sext7
- Sub-module risc16_regfile: 8x16, two async read ports, one sync write port, r0 hardwired to 0. Async active-low reset clears r1..r7.

Test Plan:
- Reset with RESET_PC=16'h0100, zero-wait memory → first mem_addr=0x0100. Program "addi r1,r0,5; addi r2,r1,-3; add r3,r1,r2; halt" → r3=7, halt=1, pc_out=0x0103, instret=4, 2 cycles per ALU instruction.
- Memory with 3 wait states on every access: "lui r1,0x3FF; sw r1,r0,10; lw r2,r0,10" → mem_addr=10 write data 0xFFC0, r2=0xFFC0. mem_addr/we/wdata held stable through all wait cycles.
- Branches: beq r0,r0,+2 at 0x0004 → next fetch at 0x0007. beq r1,r2 with r1≠r2 → next fetch pc+1. imm7=-64 at pc 0x0000 → fetch at 0xFFC1 (wrap).
- jalr r1,r1 with r1=0x0020 at pc 0x0005 → next fetch at 0x0020, r1=0x0006. addi r0,r0,7 → r0 still 0.
- Assert reset while MEM of an lw is waiting on ack → mem_req falls within the same cycle, no register write, restart fetch at RESET_PC, instret=0.
- HALT: with mem_ack held high, stay ≥20 cycles with mem_req=0 and instret constant. ADDR_WIDTH=8 build: an lw to 0x1234 drives mem_addr=0x34.

Source files
------------

// File: rtl/risc16_pkg.sv
// risc16_pkg: shared opcodes, FSM states and helpers for the multicycle RiSC-16 core.
package risc16_pkg;
    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_ADDI = 3'd1;
    localparam logic [2:0] OP_NAND = 3'd2;
    localparam logic [2:0] OP_LUI  = 3'd3;
    localparam logic [2:0] OP_SW   = 3'd4;
    localparam logic [2:0] OP_LW   = 3'd5;
    localparam logic [2:0] OP_BEQ  = 3'd6;
    localparam logic [2:0] OP_JALR = 3'd7;

    localparam logic [15:0] HALT_INSTR = 16'hC07F;

    typedef enum logic [1:0] {FETCH, EXEC, MEM, HALT} state_t;

    function automatic logic [15:0] sext7(input logic [6:0] imm);
        return {{9{imm[6]}}, imm};
    endfunction
endpackage

// File: rtl/risc16_regfile.sv
// risc16_regfile: 8x16 register file, two async read ports, one sync write port, r0 reads as zero.
module risc16_regfile (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  ra1,
    input  logic [2:0]  ra2,
    output logic [15:0] rd1,
    output logic [15:0] rd2,
    input  logic        we,
    input  logic [2:0]  wa,
    input  logic [15:0] wd
);
    logic [15:0] r [8];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 8; i++) r[i] <= '0;
        end else if (we && wa != 3'd0) begin
            r[wa] <= wd;
        end
    end

    assign rd1 = ra1 == 3'd0 ? 16'h0000 : r[ra1];
    assign rd2 = ra2 == 3'd0 ? 16'h0000 : r[ra2];
endmodule

// File: rtl/risc16_mc_cpu.sv
// risc16_mc_cpu: multicycle RiSC-16 core sequencing FETCH/EXEC/MEM over one req/ack memory bus.
module risc16_mc_cpu
    import risc16_pkg::*;
#(
    parameter logic [15:0] RESET_PC   = 16'h0000,
    parameter int          ADDR_WIDTH = 16,
    parameter int          CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [15:0]           mem_wdata,
    input  logic [15:0]           mem_rdata,
    input  logic                  mem_ack,
    output logic                  halt,
    output logic [15:0]           pc_out,
    output logic [CNT_WIDTH-1:0]  instret
);
    state_t state, state_n;
    logic [15:0] pc, ir, ea, sdata, rd1, rd2, wd, alu, imm, pc1, pc_n, addr;
    logic [2:0]  op;
    logic        ack, is_mem, wb;

    assign op     = ir[15:13];
    assign imm    = sext7(ir[6:0]);
    assign pc1    = pc + 16'd1;
    assign is_mem = op == OP_LW || op == OP_SW;
    // reset gates the request so an in-flight transfer is abandoned immediately
    assign mem_req   = reset && (state == FETCH || state == MEM);
    assign ack       = mem_req && mem_ack;
    assign mem_we    = state == MEM && op == OP_SW;
    assign addr      = state == MEM ? ea : pc;
    assign mem_addr  = ADDR_WIDTH'(addr);
    assign mem_wdata = sdata;
    assign halt      = state == HALT;
    assign pc_out    = pc;

    assign alu  = op == OP_ADD  ? rd1 + rd2 :
                  op == OP_NAND ? ~(rd1 & rd2) :
                  op == OP_LUI  ? {ir[9:0], 6'b0} :
                  op == OP_JALR ? pc1 : rd1 + imm;
    assign pc_n = op == OP_JALR ? rd1 : (op == OP_BEQ && rd1 == rd2) ? pc1 + imm : pc1;
    assign wb   = state == EXEC ? !is_mem && op != OP_BEQ : state == MEM && ack && op == OP_LW;
    assign wd   = state == MEM ? mem_rdata : alu;

    risc16_regfile u_rf (
        .clk (clk),
        .reset (reset),
        .ra1 (ir[9:7]),
        .ra2 ((op == OP_ADD || op == OP_NAND) ? ir[2:0] : ir[12:10]),
        .rd1 (rd1),
        .rd2 (rd2),
        .we  (wb),
        .wa  (ir[12:10]),
        .wd  (wd)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= FETCH;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            FETCH:   state_n = ack ? EXEC : FETCH;
            EXEC:    state_n = ir == HALT_INSTR ? HALT : is_mem ? MEM : FETCH;
            MEM:     state_n = ack ? FETCH : MEM;
            default: state_n = HALT;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc      <= RESET_PC;
            ir      <= '0;
            ea      <= '0;
            sdata   <= '0;
            instret <= '0;
        end else begin
            if (state == FETCH && ack) ir <= mem_rdata;
            if (state == EXEC && is_mem) begin
                ea    <= alu;
                sdata <= rd2;
            end
            if (state == EXEC && !is_mem && ir != HALT_INSTR) pc <= pc_n;
            if (state == MEM && ack) pc <= pc1;
            if ((state == EXEC && !is_mem) || (state == MEM && ack)) instret <= instret + CNT_WIDTH'(1);
        end
    end
endmodule

// File: tb/tb_risc16_mc_cpu.sv
// tb_risc16_mc_cpu: directed program vectors plus hand sequences for waits, reset abort, halt and narrow bus.
module tb_risc16_mc_cpu;
    import risc16_pkg::*;

    typedef struct {
        logic [7:0][15:0] prog;
        int               waits;
        logic [31:0]      exp_mem;
        logic [31:0]      exp_ret;
        int               exp_cyc;
        logic [31:0]      exp_pc;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset = 1'b0, reset8 = 1'b0;
    logic mem_req, mem_we, mem_ack, halt;
    logic [15:0] mem_addr, mem_wdata, mem_rdata, pc_out;
    logic [31:0] instret;
    logic req8, we8, ack8, halt8;
    logic [7:0] addr8;
    logic [15:0] wdata8, rdata8, pc8;
    logic [31:0] ret8;

    logic [15:0] mem [65536];
    logic [15:0] mem8 [256];
    int waits = 0, cnt = 0;
    logic force_ack = 1'b0;
    logic ld_we = 1'b0, ld_sel = 1'b0;
    logic [15:0] ld_addr = '0, ld_data = '0;
    int checks = 0, errors = 0;
    vec_t vt [10];

    assign mem_ack   = force_ack || (mem_req && cnt >= waits);
    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) begin
        if (ld_we && !ld_sel) mem[ld_addr] <= ld_data;
        else if (mem_req && mem_ack && mem_we) mem[mem_addr] <= mem_wdata;
        cnt <= (mem_req && !mem_ack) ? cnt + 1 : 0;
    end

    assign ack8   = req8;
    assign rdata8 = mem8[addr8];
    always @(posedge clk) begin
        if (ld_we && ld_sel) mem8[ld_addr[7:0]] <= ld_data;
        else if (req8 && we8) mem8[addr8] <= wdata8;
    end

    risc16_mc_cpu #(.RESET_PC(16'h0100)) dut (
        .clk(clk), .reset(reset), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .halt(halt),
        .pc_out(pc_out), .instret(instret)
    );

    risc16_mc_cpu #(.RESET_PC(16'h0000), .ADDR_WIDTH(8)) dut8 (
        .clk(clk), .reset(reset8), .mem_req(req8), .mem_we(we8), .mem_addr(addr8),
        .mem_wdata(wdata8), .mem_rdata(rdata8), .mem_ack(ack8), .halt(halt8),
        .pc_out(pc8), .instret(ret8)
    );

    // bus must hold address/direction/data while a request waits for its ack
    logic pend = 1'b0, s_we = 1'b0;
    logic [15:0] s_addr = '0, s_wdata = '0;
    int stab_err = 0;
    always @(negedge clk) begin
        if (pend && reset && mem_req && {mem_addr, mem_we, mem_wdata} !== {s_addr, s_we, s_wdata}) begin
            stab_err <= stab_err + 1;
            $display("FAIL bus_stable actual=%h/%b/%h required=%h/%b/%h", mem_addr, mem_we, mem_wdata, s_addr, s_we, s_wdata);
        end
        pend    <= reset && mem_req && !mem_ack;
        s_addr  <= mem_addr;
        s_we    <= mem_we;
        s_wdata <= mem_wdata;
    end

    function automatic logic [15:0] rri(input int op, input int a, input int b, input int imm);
        logic [31:0] o, x, y, t;
        o = op; x = a; y = b; t = imm;
        return {o[2:0], x[2:0], y[2:0], t[6:0]};
    endfunction

    function automatic logic [15:0] rrr(input int op, input int a, input int b, input int c);
        logic [31:0] o, x, y, z;
        o = op; x = a; y = b; z = c;
        return {o[2:0], x[2:0], y[2:0], 4'b0, z[2:0]};
    endfunction

    function automatic logic [15:0] ri(input int op, input int a, input int imm);
        logic [31:0] o, x, t;
        o = op; x = a; t = imm;
        return {o[2:0], x[2:0], t[9:0]};
    endfunction

    function automatic vec_t mk(input logic [15:0] p0, p1, p2, p3, p4, p5, input int w,
                                input logic [31:0] m, input logic [31:0] r, input int c, input logic [31:0] p);
        vec_t v;
        v.prog = {8{HALT_INSTR}};
        v.prog[0] = p0; v.prog[1] = p1; v.prog[2] = p2;
        v.prog[3] = p3; v.prog[4] = p4; v.prog[5] = p5;
        v.waits = w; v.exp_mem = m; v.exp_ret = r; v.exp_cyc = c; v.exp_pc = p;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic load(input logic sel, input logic [15:0] a, input logic [15:0] d);
        ld_sel = sel; ld_addr = a; ld_data = d; ld_we = 1'b1;
        @(posedge clk); #1;
        ld_we = 1'b0;
    endtask

    task automatic run_halt(input int budget, output int cyc);
        cyc = 0;
        while (!halt && cyc < budget) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    initial begin
        int cyc;
        logic found;
        localparam logic [15:0] H = HALT_INSTR;
        vt[0] = mk(rri(1,1,0,5), rri(1,2,1,-3), rrr(0,3,1,2), rri(4,3,0,32), H, H, 0, 32'h7, 5, 11, 32'h104);
        vt[1] = mk(rri(1,1,0,-1), rri(1,2,0,15), rrr(2,3,1,2), rri(4,3,0,32), H, H, 0, 32'hFFF0, 5, 11, 32'h104);
        vt[2] = mk(ri(3,1,10'h3FF), rri(4,1,0,32), H, H, H, H, 0, 32'hFFC0, 3, 7, 32'h102);
        vt[3] = mk(rri(1,0,0,7), rri(4,0,0,32), H, H, H, H, 0, 32'h0, 3, 7, 32'h102);
        vt[4] = mk(ri(3,1,10'h3FF), rri(1,1,1,63), rri(1,1,1,2), rri(4,1,0,32), H, H, 0, 32'h1, 5, 11, 32'h104);
        vt[5] = mk(rri(6,0,0,2), rri(1,1,0,1), rri(1,1,0,2), rri(1,1,0,3), rri(4,1,0,32), H, 0, 32'h3, 4, 9, 32'h105);
        vt[6] = mk(rri(1,1,0,1), rri(6,1,0,1), rri(1,2,0,9), rri(4,2,0,32), H, H, 0, 32'h9, 5, 11, 32'h104);
        vt[7] = mk(ri(3,1,4), rri(1,1,1,4), rri(7,1,1,0), H, rri(4,1,0,32), H, 0, 32'h103, 5, 11, 32'h105);
        vt[8] = mk(rri(1,1,0,-7), rri(4,1,0,33), rri(5,2,0,33), rri(4,2,0,32), H, H, 0, 32'hFFF9, 5, 13, 32'h104);
        vt[9] = mk(ri(3,1,10'h3FF), rri(4,1,0,10), rri(5,2,0,10), rri(4,2,0,32), H, H, 3, 32'hFFC0, 5, 37, 32'h104);

        repeat (2) @(posedge clk); #1;
        chk("rst_req", 32'(mem_req), 32'h0);
        chk("rst_halt", 32'(halt), 32'h0);
        chk("rst_addr", 32'(mem_addr), 32'h100);
        chk("rst_wdata", 32'(mem_wdata), 32'h0);
        chk("rst_instret", instret, 32'h0);
        chk("rst_pc", 32'(pc_out), 32'h100);

        load(1'b0, 16'h100, rri(1,1,0,5));
        load(1'b0, 16'h101, rri(1,2,1,-3));
        load(1'b0, 16'h102, rrr(0,3,1,2));
        load(1'b0, 16'h103, H);
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        chk("first_req", 32'(mem_req), 32'h1);
        chk("first_addr", 32'(mem_addr), 32'h100);
        run_halt(100, cyc);
        chk("alu_cycles", cyc, 8);
        chk("alu_pc", 32'(pc_out), 32'h103);
        chk("alu_instret", instret, 32'd4);
        chk("alu_halt", 32'(halt), 32'h1);
        force_ack = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            chk("halt_req", 32'(mem_req), 32'h0);
            chk("halt_instret", instret, 32'd4);
        end
        force_ack = 1'b0;

        for (int i = 0; i < 10; i++) begin
            reset = 1'b0;
            for (int k = 0; k < 8; k++) load(1'b0, 16'h0100 + 16'(k), vt[i].prog[k]);
            load(1'b0, 16'd32, 16'hDEAD);
            load(1'b0, 16'd33, 16'h0000);
            load(1'b0, 16'd10, 16'h0000);
            waits = vt[i].waits;
            @(posedge clk); #1;
            reset = 1'b1;
            run_halt(200, cyc);
            chk($sformatf("v%0d_mem", i), 32'(mem[32]), vt[i].exp_mem);
            chk($sformatf("v%0d_instret", i), instret, vt[i].exp_ret);
            chk($sformatf("v%0d_cycles", i), cyc, vt[i].exp_cyc);
            chk($sformatf("v%0d_pc", i), 32'(pc_out), vt[i].exp_pc);
        end
        chk("sw_wait_data", 32'(mem[10]), 32'hFFC0);

        reset = 1'b0;
        load(1'b0, 16'h100, rri(5,1,0,33));
        load(1'b0, 16'h101, H);
        waits = 5;
        @(posedge clk); #1;
        reset = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            @(posedge clk); #1;
            found = mem_req && mem_addr == 16'd33;
        end
        chk("abort_lw_seen", 32'(found), 32'h1);
        #2;
        reset = 1'b0;
        #1;
        chk("abort_req", 32'(mem_req), 32'h0);
        chk("abort_instret", instret, 32'h0);
        chk("abort_pc", 32'(pc_out), 32'h100);
        chk("abort_addr", 32'(mem_addr), 32'h100);
        @(posedge clk); #1;
        waits = 0;
        reset = 1'b1;
        #1;
        chk("restart_req", 32'(mem_req), 32'h1);
        chk("restart_addr", 32'(mem_addr), 32'h100);
        run_halt(100, cyc);
        chk("restart_cycles", cyc, 5);
        chk("restart_instret", instret, 32'd2);

        load(1'b1, 16'h00, 16'hC040);
        load(1'b1, 16'hC1, ri(3,1,10'h048));
        load(1'b1, 16'hC2, rri(1,1,1,52));
        load(1'b1, 16'hC3, rri(5,2,1,0));
        load(1'b1, 16'hC4, rri(4,2,0,5));
        load(1'b1, 16'hC5, H);
        load(1'b1, 16'h34, 16'hBEEF);
        load(1'b1, 16'h05, 16'h0000);
        @(posedge clk); #1;
        reset8 = 1'b1;
        repeat (2) @(posedge clk); #1;
        chk("wrap_pc", 32'(pc8), 32'hFFC1);
        chk("wrap_addr", 32'(addr8), 32'hC1);
        repeat (6) @(posedge clk); #1;
        chk("narrow_req", 32'(req8), 32'h1);
        chk("narrow_we", 32'(we8), 32'h0);
        chk("narrow_addr", 32'(addr8), 32'h34);
        for (int i = 0; i < 50 && !halt8; i++) begin
            @(posedge clk); #1;
        end
        chk("narrow_data", 32'(mem8[5]), 32'hBEEF);
        chk("narrow_pc", 32'(pc8), 32'hFFC5);
        chk("narrow_instret", ret8, 32'd6);

        chk("bus_stable_errs", stab_err, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
